// File: rtl/comp_sched_pkg.sv
// rtl/comp_sched_pkg.sv - shared encodings and defaults for the compression command scheduler
package comp_sched_pkg;

    typedef enum logic [1:0] {
        CMD_NOP        = 2'b00,
        CMD_COMPRESS   = 2'b01,
        CMD_DECOMPRESS = 2'b10,
        CMD_RSVD       = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_OK   = 2'b01,
        RESP_ERR  = 2'b10,
        RESP_RSVD = 2'b11
    } resp_e;

    // STATUS_NONE is only the reset value; a delivered response never carries it.
    typedef enum logic [1:0] {
        STATUS_NONE    = 2'b00,
        STATUS_OK      = 2'b01,
        STATUS_ERR     = 2'b10,
        STATUS_TIMEOUT = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } sched_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/comp_rr_arb2.sv
// rtl/comp_rr_arb2.sv - two-way round-robin grant, favouring the requester at rr_ptr
module comp_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[rr_ptr]) begin
            grant[rr_ptr] = 1'b1;
        end else if (valid[~rr_ptr]) begin
            grant[~rr_ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/comp_cmd_scheduler.sv
// rtl/comp_cmd_scheduler.sv - shares one compression engine between two requesters, one command in flight
module comp_cmd_scheduler
    import comp_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][1:0]            req_cmd,
    input  logic [1:0][DATA_WIDTH-1:0] req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [1:0]                 rsp_status,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 eng_command,
    output logic [DATA_WIDTH-1:0]      eng_data_in,
    output logic [DATA_WIDTH-1:0]      eng_compressed_in,
    input  logic [DATA_WIDTH-1:0]      eng_compressed_out,
    input  logic [DATA_WIDTH-1:0]      eng_decompressed_out,
    input  logic [1:0]                 eng_response,
    output logic                       spurious_rsp
);

    sched_state_e          state_q, state_d;
    cmd_e                  cmd_q;
    logic [DATA_WIDTH-1:0] op_q;
    logic                  id_q;
    status_e               status_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  rr_ptr_q;
    logic                  spurious_q;

    logic [1:0] grant;
    logic       accept;
    logic       acc_id;
    cmd_e       acc_cmd;
    logic       acc_cmd_ok;
    resp_e      resp;
    logic       timed_out;

    comp_rr_arb2 u_arb (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (grant)
    );

    assign req_ready  = (state_q == S_IDLE) ? grant : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign acc_id     = grant[1];
    assign acc_cmd    = cmd_e'(req_cmd[acc_id]);
    assign acc_cmd_ok = (acc_cmd == CMD_COMPRESS) || (acc_cmd == CMD_DECOMPRESS);
    assign resp       = resp_e'(eng_response);
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign timed_out  = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = acc_cmd_ok ? S_ISSUE : S_RESP;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (resp != RESP_NONE || timed_out) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q      <= CMD_NOP;
            op_q       <= '0;
            id_q       <= 1'b0;
            status_q   <= STATUS_NONE;
            data_q     <= '0;
            cnt_q      <= '0;
            rr_ptr_q   <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            if (state_q != S_WAIT && resp != RESP_NONE) begin
                spurious_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cmd_q <= acc_cmd;
                        op_q  <= req_data[acc_id];
                        id_q  <= acc_id;
                        if (!acc_cmd_ok) begin
                            status_q <= STATUS_ERR;
                            data_q   <= '0;
                        end
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_inc;
                    // A response landing on the timeout cycle wins over the timeout.
                    case (resp)
                        RESP_OK: begin
                            status_q <= STATUS_OK;
                            data_q   <= (cmd_q == CMD_COMPRESS) ? eng_compressed_out
                                                                : eng_decompressed_out;
                        end
                        RESP_NONE: begin
                            if (timed_out) begin
                                status_q <= STATUS_TIMEOUT;
                                data_q   <= '0;
                            end
                        end
                        default: begin
                            status_q <= STATUS_ERR;
                            data_q   <= '0;
                        end
                    endcase
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q <= ~id_q;
                        cmd_q    <= CMD_NOP;
                        op_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand buses follow the latched command until the response is handed back.
    assign eng_command       = (state_q == S_ISSUE) ? cmd_q : CMD_NOP;
    assign eng_data_in       = (cmd_q == CMD_COMPRESS)   ? op_q : '0;
    assign eng_compressed_in = (cmd_q == CMD_DECOMPRESS) ? op_q : '0;

    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_id       = id_q;
    assign rsp_status   = status_q;
    assign rsp_data     = data_q;
    assign spurious_rsp = spurious_q;

endmodule

// File: tb/tb_comp_cmd_scheduler.sv
// tb/tb_comp_cmd_scheduler.sv - directed self-checking bench for comp_cmd_scheduler
module tb_comp_cmd_scheduler;
    import comp_sched_pkg::*;

    localparam int DW = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         req_valid = '0;
    logic [1:0]         req_ready;
    logic [1:0][1:0]    req_cmd = '0;
    logic [1:0][DW-1:0] req_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               rsp_id;
    logic [1:0]         rsp_status;
    logic [DW-1:0]      rsp_data;
    logic [1:0]         eng_command;
    logic [DW-1:0]      eng_data_in;
    logic [DW-1:0]      eng_compressed_in;
    logic [DW-1:0]      eng_compressed_out = '0;
    logic [DW-1:0]      eng_decompressed_out = '0;
    logic [1:0]         eng_response = '0;
    logic               spurious_rsp;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    comp_cmd_scheduler #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_cmd              (req_cmd),
        .req_data             (req_data),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_id               (rsp_id),
        .rsp_status           (rsp_status),
        .rsp_data             (rsp_data),
        .eng_command          (eng_command),
        .eng_data_in          (eng_data_in),
        .eng_compressed_in    (eng_compressed_in),
        .eng_compressed_out   (eng_compressed_out),
        .eng_decompressed_out (eng_decompressed_out),
        .eng_response         (eng_response),
        .spurious_rsp         (spurious_rsp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int waits;
        logic [1:0] exp_ready;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_eng_command", eng_command, 2'b00);
        check("rst_spurious", spurious_rsp, 1'b0);
        check("rst_rsp_status", rsp_status, 2'b00);
        reset = 1'b0;

        // Req0 COMPRESS A5, engine OK two cycles after the command
        req_valid = 2'b01; req_cmd[0] = 2'b01; req_data[0] = 8'hA5;
        #1;
        check("t1_req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("t1_issue_cmd", eng_command, 2'b01);
        check("t1_data_in", eng_data_in, 8'hA5);
        check("t1_comp_in", eng_compressed_in, 8'h00);
        tick();
        check("t1_wait_cmd", eng_command, 2'b00);
        check("t1_wait_data_in", eng_data_in, 8'hA5);
        check("t1_wait_valid", rsp_valid, 1'b0);
        tick();
        eng_response = 2'b01; eng_compressed_out = 8'h3C;
        check("t1_early_valid", rsp_valid, 1'b0);
        tick();
        eng_response = 2'b00;
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_rsp_id", rsp_id, 1'b0);
        check("t1_rsp_status", rsp_status, 2'b01);
        check("t1_rsp_data", rsp_data, 8'h3C);
        rsp_ready = 1'b1;
        tick();
        check("t1_after_valid", rsp_valid, 1'b0);
        check("t1_after_data_in", eng_data_in, 8'h00);

        // Both requesters valid from reset: order 0,1,0
        do_reset();
        req_valid = 2'b11;
        req_cmd[0] = 2'b01; req_data[0] = 8'h11;
        req_cmd[1] = 2'b10; req_data[1] = 8'h22;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_ready = (k == 1) ? 2'b10 : 2'b01;
            check($sformatf("t2_ready_%0d", k), req_ready, exp_ready);
            tick();
            check($sformatf("t2_cmd_%0d", k), eng_command, (k == 1) ? 2'b10 : 2'b01);
            check($sformatf("t2_data_in_%0d", k), eng_data_in, (k == 1) ? 8'h00 : 8'h11);
            check($sformatf("t2_comp_in_%0d", k), eng_compressed_in, (k == 1) ? 8'h22 : 8'h00);
            tick();
            eng_response = 2'b01;
            eng_compressed_out = 8'hC0 + 8'(k);
            eng_decompressed_out = 8'hD0 + 8'(k);
            tick();
            eng_response = 2'b00;
            check($sformatf("t2_rsp_valid_%0d", k), rsp_valid, 1'b1);
            check($sformatf("t2_rsp_id_%0d", k), rsp_id, (k == 1) ? 1'b1 : 1'b0);
            check($sformatf("t2_rsp_data_%0d", k), rsp_data, (k == 1) ? 8'hD1 : 8'hC0 + 8'(k));
            tick();
        end
        req_valid = 2'b00;

        // Engine never responds: timeout after 16 WAIT cycles
        req_valid = 2'b01; req_cmd[0] = 2'b01; req_data[0] = 8'h55;
        #1;
        check("t3_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("t3_issue", eng_command, 2'b01);
        waits = 0;
        rsp_ready = 1'b0;
        while (!rsp_valid && waits < 40) begin
            tick();
            waits++;
        end
        check("t3_wait_cycles", waits - 1, 16);
        check("t3_status", rsp_status, 2'b11);
        check("t3_data", rsp_data, 8'h00);
        check("t3_id", rsp_id, 1'b0);
        rsp_ready = 1'b1;
        tick();

        // Req1 reserved command: immediate ERR, engine untouched
        req_valid = 2'b10; req_cmd[1] = 2'b11; req_data[1] = 8'h77;
        #1;
        check("t4_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        check("t4_cmd", eng_command, 2'b00);
        check("t4_rsp_valid", rsp_valid, 1'b1);
        check("t4_status", rsp_status, 2'b10);
        check("t4_id", rsp_id, 1'b1);
        check("t4_data", rsp_data, 8'h00);
        check("t4_comp_in", eng_compressed_in, 8'h00);
        tick();

        // Backpressure in RESP, spurious response in RESP
        rsp_ready = 1'b0;
        req_valid = 2'b01; req_cmd[0] = 2'b01; req_data[0] = 8'h9A;
        tick();
        req_valid = 2'b11; req_cmd[1] = 2'b10;
        tick();
        eng_response = 2'b01; eng_compressed_out = 8'h4D;
        tick();
        eng_response = 2'b00; eng_compressed_out = 8'h00;
        check("t5_spurious_pre", spurious_rsp, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t5_valid_%0d", c), rsp_valid, 1'b1);
            check($sformatf("t5_data_%0d", c), rsp_data, 8'h4D);
            check($sformatf("t5_status_%0d", c), rsp_status, 2'b01);
            check($sformatf("t5_ready_%0d", c), req_ready, 2'b00);
            eng_response = (c == 1) ? 2'b01 : 2'b00;
            tick();
        end
        eng_response = 2'b00;
        check("t5_spurious", spurious_rsp, 1'b1);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("t5_spurious_sticky", spurious_rsp, 1'b1);

        // Async reset mid-WAIT, then arbitration from rr_ptr=0
        req_valid = 2'b01; req_cmd[0] = 2'b01; req_data[0] = 8'hE7;
        tick();
        req_valid = 2'b00;
        tick();
        check("t6_wait_data_in", eng_data_in, 8'hE7);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_data_in", eng_data_in, 8'h00);
        check("t6_rst_cmd", eng_command, 2'b00);
        check("t6_rst_valid", rsp_valid, 1'b0);
        check("t6_rst_spurious", spurious_rsp, 1'b0);
        check("t6_rst_ready", req_ready, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_cmd[0] = 2'b01; req_cmd[1] = 2'b01;
        req_valid = 2'b11;
        #1;
        check("t6_both_ready", req_ready, 2'b01);
        req_valid = 2'b10;
        #1;
        check("t6_req1_ready", req_ready, 2'b10);
        req_valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
